wt_l15_req_arb: RTL and testbench
=================================

WT_L15_REQ_ARB -- requirements
Module: wt_l15_req_arb

Interface
REQ-001 SHALL have parameter PADDR_W, default 56, physical address width.
REQ-002 SHALL have parameter TID_W, default L15_TID_WIDTH, transaction ID width.
REQ-003 SHALL have parameter MAX_OUTST, default 2, outstanding-request limit per requester (1..7).
REQ-004 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ic_req_valid_i in 1 / ic_req_ready_o out 1  icache fill handshake.
REQ-007 SHALL have ports ic_req_paddr_i in PADDR_W, ic_req_nc_i in 1, ic_req_tid_i in TID_W  icache fill payload.
REQ-008 SHALL have ports dc_req_valid_i in 1 / dc_req_ready_o out 1  dcache request handshake.
REQ-009 SHALL have ports dc_req_type_i in dcache_out_t, dc_req_paddr_i in PADDR_W, dc_req_size_i in 3, dc_req_data_i in 64, dc_req_nc_i in 1, dc_req_tid_i in TID_W  dcache payload.
REQ-010 SHALL have ports ic_rtrn_i in 1, dc_rtrn_i in 1  one-cycle pulses, one completed request per pulse.
REQ-011 SHALL have ports l15_req_valid_o out 1 / l15_req_ready_i in 1  request channel to L1.5 adapter.
REQ-012 SHALL have ports l15_req_rqtype_o out l15_reqtypes_t, l15_req_paddr_o out PADDR_W, l15_req_size_o out 3, l15_req_data_o out 64, l15_req_nc_o out 1, l15_req_tid_o out TID_W, l15_req_src_o out 1 (0=icache, 1=dcache).

Function
REQ-013 SHALL grant at most one requester per cycle; grant occurs when requester valid, requester eligible, and output register free.
REQ-014 Output register free SHALL mean empty, or full and l15_req_ready_i=1 that cycle (back-to-back at full throughput).
REQ-015 Arbitration SHALL be round-robin: on contention, grant the requester pointed to; after any grant, pointer moves to the other requester.
REQ-016 ic_req_ready_o / dc_req_ready_o SHALL equal the grant signal for that requester (ready only when granted, combinationally from valid).
REQ-017 Granted payload SHALL be registered; latency req-accept to l15_req_valid_o = 1 cycle; outputs stable while valid and not ready.
REQ-018 Type mapping SHALL be: icache -> L15_IMISS_RQ, size 3'b111; DCACHE_LOAD_REQ -> L15_LOAD_RQ; DCACHE_STORE_REQ -> L15_STORE_RQ; DCACHE_ATOMIC_REQ -> L15_ATOMIC_RQ; DCACHE_INT_REQ -> L15_INT_RQ; dcache size passes through; icache data output = 0.
REQ-019 Per-requester 3-bit outstanding counter SHALL increment on grant, decrement on that requester's rtrn pulse; simultaneous grant and return leaves it unchanged.
REQ-020 Requester SHALL be ineligible while its counter == MAX_OUTST; the other requester may then win uncontended.
REQ-021 Return pulse with counter 0 SHALL be ignored (counter stays 0) and flagged by assertion.
REQ-022 Dcache ordering FSM states: IDLE, AMO_DRAIN, AMO_WAIT.
REQ-023 IDLE: dcache atomic at head with dc counter > 0 or output register holding dcache request -> AMO_DRAIN, dcache ineligible; with counter 0 and register free of dcache -> grant, go AMO_WAIT.
REQ-024 AMO_DRAIN: dcache ineligible; when dc counter == 0 and no dcache request in register -> IDLE (atomic granted next eligible cycle).
REQ-025 AMO_WAIT: dcache ineligible; on dc_rtrn_i -> IDLE; icache unaffected in all states.
REQ-026 Non-atomic dcache requests SHALL not be reordered relative to each other (single in-order path).

Reset
REQ-027 On rst_ni low: l15_req_valid_o=0, all payload outputs 0, counters 0, FSM IDLE, RR pointer = icache; requests mid-handshake are dropped, no partial output.
REQ-028 Ready outputs SHALL be 0 while rst_ni is low.

Structure
REQ-029 dcache_out_t, l15_reqtypes_t and the requester-source encoding SHALL live in wt_cache_pkg; MAX_OUTST default added there as a localparam.
REQ-030 One sub-module is natural: rr_arb_2 (2-way round-robin grant with pointer); counters, FSM and output register stay in top.

Verification
REQ-031 Both valid every cycle, ready_i=1, limits not hit -> grants alternate ic,dc,ic,dc; l15_req_src_o 0,1,0,1 one cycle after each accept.
REQ-032 Dcache 2 loads, no returns, MAX_OUTST=2 -> third load stalls (dc_req_ready_o=0) until one dc_rtrn_i pulse, granted next cycle.
REQ-033 Dcache load outstanding, then atomic -> FSM AMO_DRAIN, icache still served; after dc_rtrn_i atomic issued as L15_ATOMIC_RQ; following store held until atomic's return.
REQ-034 l15_req_ready_i=0 for 5 cycles with request valid -> outputs unchanged all 5 cycles; no new grant; single transfer when ready rises.
REQ-035 rst_ni asserted mid-stall with counters 2/1 -> all outputs 0 immediately, counters 0 after release, first request accepted cycle after valid.
REQ-036 Spurious ic_rtrn_i with counter 0 -> counter stays 0, assertion fires, no output change.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through cache to L1.5 request path.
package wt_cache_pkg;

  // Transaction ID width towards the L1.5 adapter.
  localparam int unsigned L15_TID_WIDTH = 2;

  // Default per-requester outstanding-request limit (legal range 1..7).
  localparam int unsigned WT_L15_MAX_OUTST = 2;

  // Request kinds produced by the dcache.
  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ   = 2'b00,
    DCACHE_STORE_REQ  = 2'b01,
    DCACHE_ATOMIC_REQ = 2'b10,
    DCACHE_INT_REQ    = 2'b11
  } dcache_out_t;

  // Request types understood by the L1.5 adapter.
  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_ATOMIC_RQ = 5'b00110,
    L15_INT_RQ    = 5'b01001,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  // Requester-source encoding carried on l15_req_src_o.
  localparam logic L15_SRC_IC = 1'b0;
  localparam logic L15_SRC_DC = 1'b1;

  // Fixed size code used for icache line fills.
  localparam logic [2:0] L15_IMISS_SIZE = 3'b111;

  // Translate a dcache request kind into the L1.5 request type.
  function automatic l15_reqtypes_t dc_to_l15_type(input dcache_out_t t);
    l15_reqtypes_t r;
    case (t)
      DCACHE_LOAD_REQ:   r = L15_LOAD_RQ;
      DCACHE_STORE_REQ:  r = L15_STORE_RQ;
      DCACHE_ATOMIC_REQ: r = L15_ATOMIC_RQ;
      DCACHE_INT_REQ:    r = L15_INT_RQ;
      default:           r = L15_LOAD_RQ;
    endcase
    return r;
  endfunction

  // Outstanding-request counter update; a return with nothing outstanding is dropped.
  function automatic logic [2:0] outst_cnt_next(input logic [2:0] cnt,
                                                input logic       inc,
                                                input logic       dec);
    logic dec_ok;
    logic [2:0] nxt;
    dec_ok = dec && (cnt != 3'd0);
    nxt    = cnt;
    if (inc && !dec_ok) begin
      nxt = cnt + 3'd1;
    end else if (!inc && dec_ok) begin
      nxt = cnt - 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wt_l15_req_arb_rr.sv
// Two-way round-robin arbiter: bit 0 is the icache, bit 1 the dcache.
module rr_arb_2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Pointer to the requester that wins the next contended cycle (0 = icache).
  logic ptr_q;

  // Grant the pointed-to requester on contention, otherwise whichever asks.
  always_comb begin
    gnt_o = '0;
    if (req_i == 2'b11) begin
      gnt_o[ptr_q] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

  // After any grant, point at the requester that was not served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/wt_l15_req_arb.sv
// Arbitrates icache fills and dcache requests onto one registered L1.5 request
// channel, with per-requester outstanding limits and atomic ordering for dcache.
module wt_l15_req_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned PADDR_W   = 56,
  parameter int unsigned TID_W     = L15_TID_WIDTH,
  parameter int unsigned MAX_OUTST = WT_L15_MAX_OUTST
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // icache fill requests
  input  logic                ic_req_valid_i,
  output logic                ic_req_ready_o,
  input  logic [PADDR_W-1:0]  ic_req_paddr_i,
  input  logic                ic_req_nc_i,
  input  logic [TID_W-1:0]    ic_req_tid_i,
  // dcache requests
  input  logic                dc_req_valid_i,
  output logic                dc_req_ready_o,
  input  dcache_out_t         dc_req_type_i,
  input  logic [PADDR_W-1:0]  dc_req_paddr_i,
  input  logic [2:0]          dc_req_size_i,
  input  logic [63:0]         dc_req_data_i,
  input  logic                dc_req_nc_i,
  input  logic [TID_W-1:0]    dc_req_tid_i,
  // completion pulses
  input  logic                ic_rtrn_i,
  input  logic                dc_rtrn_i,
  // L1.5 request channel
  output logic                l15_req_valid_o,
  input  logic                l15_req_ready_i,
  output l15_reqtypes_t       l15_req_rqtype_o,
  output logic [PADDR_W-1:0]  l15_req_paddr_o,
  output logic [2:0]          l15_req_size_o,
  output logic [63:0]         l15_req_data_o,
  output logic                l15_req_nc_o,
  output logic [TID_W-1:0]    l15_req_tid_o,
  output logic                l15_req_src_o
);

  // Dcache ordering states.
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] AMO_DRAIN = 2'd1;
  localparam logic [1:0] AMO_WAIT  = 2'd2;

  localparam logic [2:0] CNT_MAX = 3'(MAX_OUTST);

  logic [2:0]          ic_cnt_q;
  logic [2:0]          dc_cnt_q;
  logic [1:0]          state_q;
  logic [1:0]          state_d;

  logic                full_q;
  l15_reqtypes_t       rqtype_q;
  logic [PADDR_W-1:0]  paddr_q;
  logic [2:0]          size_q;
  logic [63:0]         data_q;
  logic                nc_q;
  logic [TID_W-1:0]    tid_q;
  logic                src_q;

  logic                reg_free;
  logic                dc_in_reg;
  logic                dc_is_amo;
  logic                dc_drained;
  logic                ic_elig;
  logic                dc_elig;
  logic [1:0]          arb_req;
  logic [1:0]          arb_gnt;
  logic                ic_gnt;
  logic                dc_gnt;

  // The output slot can take a new request if empty or being emptied this cycle.
  assign reg_free   = ~full_q | l15_req_ready_i;
  assign dc_in_reg  = full_q & (src_q == L15_SRC_DC);
  assign dc_is_amo  = (dc_req_type_i == DCACHE_ATOMIC_REQ);
  assign dc_drained = (dc_cnt_q == 3'd0) & ~dc_in_reg;
  assign ic_elig    = (ic_cnt_q != CNT_MAX);

  // Dcache eligibility: atomics only issue once all earlier dcache traffic is done,
  // and nothing from the dcache issues while an atomic is draining or in flight.
  always_comb begin
    dc_elig = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_is_amo) begin
          dc_elig = dc_drained;
        end else begin
          dc_elig = (dc_cnt_q != CNT_MAX);
        end
      end
      default: dc_elig = 1'b0;
    endcase
  end

  // Requests reaching the arbiter; reset suppresses every handshake.
  assign arb_req = {dc_req_valid_i & dc_elig & reg_free,
                    ic_req_valid_i & ic_elig & reg_free} & {2{rst_ni}};

  rr_arb_2 i_rr_arb_2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (arb_req),
    .gnt_o  (arb_gnt)
  );

  assign ic_gnt         = arb_gnt[0];
  assign dc_gnt         = arb_gnt[1];
  assign ic_req_ready_o = ic_gnt;
  assign dc_req_ready_o = dc_gnt;

  // Ordering FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dc_req_valid_i && dc_is_amo) begin
          if (!dc_drained) begin
            state_d = AMO_DRAIN;
          end else if (dc_gnt) begin
            state_d = AMO_WAIT;
          end
        end
      end
      AMO_DRAIN: begin
        if (dc_drained) begin
          state_d = IDLE;
        end
      end
      AMO_WAIT: begin
        if (dc_rtrn_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ordering FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outstanding counters: up on grant, down on the matching return pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
    end else begin
      ic_cnt_q <= outst_cnt_next(ic_cnt_q, ic_gnt, ic_rtrn_i);
      dc_cnt_q <= outst_cnt_next(dc_cnt_q, dc_gnt, dc_rtrn_i);
    end
  end

  // Output register: capture the granted payload, hold it until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q   <= 1'b0;
      rqtype_q <= L15_LOAD_RQ;
      paddr_q  <= '0;
      size_q   <= '0;
      data_q   <= '0;
      nc_q     <= 1'b0;
      tid_q    <= '0;
      src_q    <= L15_SRC_IC;
    end else if (ic_gnt) begin
      full_q   <= 1'b1;
      rqtype_q <= L15_IMISS_RQ;
      paddr_q  <= ic_req_paddr_i;
      size_q   <= L15_IMISS_SIZE;
      data_q   <= '0;
      nc_q     <= ic_req_nc_i;
      tid_q    <= ic_req_tid_i;
      src_q    <= L15_SRC_IC;
    end else if (dc_gnt) begin
      full_q   <= 1'b1;
      rqtype_q <= dc_to_l15_type(dc_req_type_i);
      paddr_q  <= dc_req_paddr_i;
      size_q   <= dc_req_size_i;
      data_q   <= dc_req_data_i;
      nc_q     <= dc_req_nc_i;
      tid_q    <= dc_req_tid_i;
      src_q    <= L15_SRC_DC;
    end else if (l15_req_ready_i) begin
      full_q   <= 1'b0;
    end
  end

  assign l15_req_valid_o  = full_q;
  assign l15_req_rqtype_o = rqtype_q;
  assign l15_req_paddr_o  = paddr_q;
  assign l15_req_size_o   = size_q;
  assign l15_req_data_o   = data_q;
  assign l15_req_nc_o     = nc_q;
  assign l15_req_tid_o    = tid_q;
  assign l15_req_src_o    = src_q;

`ifndef SYNTHESIS
  // A return pulse with nothing outstanding indicates an upstream protocol slip.
  ic_rtrn_spurious: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ic_rtrn_i && (ic_cnt_q == 3'd0)))
    else $warning("ic_rtrn_i pulse with no icache request outstanding");

  dc_rtrn_spurious: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dc_rtrn_i && (dc_cnt_q == 3'd0)))
    else $warning("dc_rtrn_i pulse with no dcache request outstanding");

  gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ic_gnt && dc_gnt));
`endif

endmodule

// File: tb/tb_wt_l15_req_arb.sv
// Directed bench for wt_l15_req_arb: arbitration, limits, atomic ordering, stalls, reset.
module tb_wt_l15_req_arb;
  import wt_cache_pkg::*;

  localparam int unsigned PADDR_W = 56;
  localparam int unsigned TID_W   = L15_TID_WIDTH;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               ic_req_valid_i = 1'b0;
  logic               ic_req_ready_o;
  logic [PADDR_W-1:0] ic_req_paddr_i = '0;
  logic               ic_req_nc_i = 1'b0;
  logic [TID_W-1:0]   ic_req_tid_i = '0;
  logic               dc_req_valid_i = 1'b0;
  logic               dc_req_ready_o;
  dcache_out_t        dc_req_type_i = DCACHE_LOAD_REQ;
  logic [PADDR_W-1:0] dc_req_paddr_i = '0;
  logic [2:0]         dc_req_size_i = '0;
  logic [63:0]        dc_req_data_i = '0;
  logic               dc_req_nc_i = 1'b0;
  logic [TID_W-1:0]   dc_req_tid_i = '0;
  logic               ic_rtrn_i = 1'b0;
  logic               dc_rtrn_i = 1'b0;
  logic               l15_req_valid_o;
  logic               l15_req_ready_i = 1'b1;
  l15_reqtypes_t      l15_req_rqtype_o;
  logic [PADDR_W-1:0] l15_req_paddr_o;
  logic [2:0]         l15_req_size_o;
  logic [63:0]        l15_req_data_o;
  logic               l15_req_nc_o;
  logic [TID_W-1:0]   l15_req_tid_o;
  logic               l15_req_src_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wt_l15_req_arb #(
    .PADDR_W   (PADDR_W),
    .TID_W     (TID_W),
    .MAX_OUTST (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ic_req_valid_i   (ic_req_valid_i),
    .ic_req_ready_o   (ic_req_ready_o),
    .ic_req_paddr_i   (ic_req_paddr_i),
    .ic_req_nc_i      (ic_req_nc_i),
    .ic_req_tid_i     (ic_req_tid_i),
    .dc_req_valid_i   (dc_req_valid_i),
    .dc_req_ready_o   (dc_req_ready_o),
    .dc_req_type_i    (dc_req_type_i),
    .dc_req_paddr_i   (dc_req_paddr_i),
    .dc_req_size_i    (dc_req_size_i),
    .dc_req_data_i    (dc_req_data_i),
    .dc_req_nc_i      (dc_req_nc_i),
    .dc_req_tid_i     (dc_req_tid_i),
    .ic_rtrn_i        (ic_rtrn_i),
    .dc_rtrn_i        (dc_rtrn_i),
    .l15_req_valid_o  (l15_req_valid_o),
    .l15_req_ready_i  (l15_req_ready_i),
    .l15_req_rqtype_o (l15_req_rqtype_o),
    .l15_req_paddr_o  (l15_req_paddr_o),
    .l15_req_size_o   (l15_req_size_o),
    .l15_req_data_o   (l15_req_data_o),
    .l15_req_nc_o     (l15_req_nc_o),
    .l15_req_tid_o    (l15_req_tid_o),
    .l15_req_src_o    (l15_req_src_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational readies settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  64'(l15_req_valid_o),  64'd0);
    check({tag, "_rqtype"}, 64'(l15_req_rqtype_o), 64'd0);
    check({tag, "_paddr"},  64'(l15_req_paddr_o),  64'd0);
    check({tag, "_size"},   64'(l15_req_size_o),   64'd0);
    check({tag, "_data"},   l15_req_data_o,        64'd0);
    check({tag, "_nc"},     64'(l15_req_nc_o),     64'd0);
    check({tag, "_tid"},    64'(l15_req_tid_o),    64'd0);
    check({tag, "_src"},    64'(l15_req_src_o),    64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset ----------------
    ic_req_valid_i = 1'b1;
    dc_req_valid_i = 1'b1;
    #2;
    check_all_zero("rst");
    check("rst_ic_ready", 64'(ic_req_ready_o), 64'd0);
    check("rst_dc_ready", 64'(dc_req_ready_o), 64'd0);
    step();
    step();
    rst_ni = 1'b1;

    // ---------------- round robin alternation ----------------
    ic_req_paddr_i = 56'h00_1000_0040;
    ic_req_nc_i    = 1'b1;
    ic_req_tid_i   = 2'd1;
    dc_req_type_i  = DCACHE_LOAD_REQ;
    dc_req_paddr_i = 56'h00_2000_0008;
    dc_req_size_i  = 3'b011;
    dc_req_data_i  = 64'hDEAD_BEEF_0123_4567;
    dc_req_nc_i    = 1'b0;
    dc_req_tid_i   = 2'd2;
    settle();
    check("rr1_ic_ready", 64'(ic_req_ready_o), 64'd1);
    check("rr1_dc_ready", 64'(dc_req_ready_o), 64'd0);
    step();
    check("rr1_valid",  64'(l15_req_valid_o),  64'd1);
    check("rr1_src",    64'(l15_req_src_o),    64'd0);
    check("rr1_rqtype", 64'(l15_req_rqtype_o), 64'(L15_IMISS_RQ));
    check("rr1_size",   64'(l15_req_size_o),   64'd7);
    check("rr1_data",   l15_req_data_o,        64'd0);
    check("rr1_paddr",  64'(l15_req_paddr_o),  64'h00_1000_0040);
    check("rr1_tid",    64'(l15_req_tid_o),    64'd1);
    check("rr1_nc",     64'(l15_req_nc_o),     64'd1);
    settle();
    check("rr2_dc_ready", 64'(dc_req_ready_o), 64'd1);
    check("rr2_ic_ready", 64'(ic_req_ready_o), 64'd0);
    step();
    check("rr2_src",    64'(l15_req_src_o),    64'd1);
    check("rr2_rqtype", 64'(l15_req_rqtype_o), 64'(L15_LOAD_RQ));
    check("rr2_size",   64'(l15_req_size_o),   64'd3);
    check("rr2_data",   l15_req_data_o,        64'hDEAD_BEEF_0123_4567);
    check("rr2_paddr",  64'(l15_req_paddr_o),  64'h00_2000_0008);
    settle();
    check("rr3_ic_ready", 64'(ic_req_ready_o), 64'd1);
    step();
    check("rr3_src", 64'(l15_req_src_o), 64'd0);
    settle();
    check("rr4_dc_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    check("rr4_src", 64'(l15_req_src_o), 64'd1);
    // both at the limit now
    settle();
    check("rr_lim_ic_ready", 64'(ic_req_ready_o), 64'd0);
    check("rr_lim_dc_ready", 64'(dc_req_ready_o), 64'd0);
    ic_req_valid_i = 1'b0;
    dc_req_valid_i = 1'b0;
    step();
    check("rr_drain_valid", 64'(l15_req_valid_o), 64'd0);
    check("rr_ic_cnt", 64'(dut.ic_cnt_q), 64'd2);
    check("rr_dc_cnt", 64'(dut.dc_cnt_q), 64'd2);
    ic_rtrn_i = 1'b1;
    dc_rtrn_i = 1'b1;
    step();
    step();
    ic_rtrn_i = 1'b0;
    dc_rtrn_i = 1'b0;
    check("rr_ic_cnt_clr", 64'(dut.ic_cnt_q), 64'd0);
    check("rr_dc_cnt_clr", 64'(dut.dc_cnt_q), 64'd0);

    // ---------------- dcache outstanding limit ----------------
    dc_req_valid_i = 1'b1;
    dc_req_type_i  = DCACHE_LOAD_REQ;
    dc_req_paddr_i = 56'h00_3000_0000;
    settle();
    check("lim_ld1_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_paddr_i = 56'h00_3000_0040;
    settle();
    check("lim_ld2_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_paddr_i = 56'h00_3000_0080;
    settle();
    check("lim_ld3_stall", 64'(dc_req_ready_o), 64'd0);
    step();
    check("lim_cnt_max", 64'(dut.dc_cnt_q), 64'd2);
    dc_rtrn_i = 1'b1;
    settle();
    check("lim_rtrn_cycle_ready", 64'(dc_req_ready_o), 64'd0);
    step();
    // grant together with a return: count holds at 1
    settle();
    check("lim_ld3_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_rtrn_i      = 1'b0;
    dc_req_valid_i = 1'b0;
    check("lim_simul_cnt", 64'(dut.dc_cnt_q), 64'd1);
    check("lim_ld3_paddr", 64'(l15_req_paddr_o), 64'h00_3000_0080);
    dc_rtrn_i = 1'b1;
    step();
    dc_rtrn_i = 1'b0;
    check("lim_cnt_clr", 64'(dut.dc_cnt_q), 64'd0);

    // ---------------- atomic ordering ----------------
    dc_req_valid_i = 1'b1;
    dc_req_type_i  = DCACHE_LOAD_REQ;
    dc_req_paddr_i = 56'h00_4000_0000;
    settle();
    check("amo_ld_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_type_i  = DCACHE_ATOMIC_REQ;
    dc_req_paddr_i = 56'h00_4000_0100;
    dc_req_data_i  = 64'h0000_0000_0000_00AA;
    ic_req_valid_i = 1'b1;
    ic_req_paddr_i = 56'h00_5000_0000;
    settle();
    check("amo_blk_dc_ready", 64'(dc_req_ready_o), 64'd0);
    check("amo_blk_ic_ready", 64'(ic_req_ready_o), 64'd1);
    step();
    check("amo_state_drain", 64'(dut.state_q), 64'd1);
    check("amo_ic_served", 64'(l15_req_src_o), 64'd0);
    ic_req_valid_i = 1'b0;
    dc_rtrn_i      = 1'b1;
    settle();
    check("amo_drain_ready", 64'(dc_req_ready_o), 64'd0);
    step();
    dc_rtrn_i = 1'b0;
    check("amo_drain_still", 64'(dut.state_q), 64'd1);
    settle();
    check("amo_drain_exit_ready", 64'(dc_req_ready_o), 64'd0);
    step();
    check("amo_state_idle", 64'(dut.state_q), 64'd0);
    settle();
    check("amo_issue_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    check("amo_rqtype", 64'(l15_req_rqtype_o), 64'(L15_ATOMIC_RQ));
    check("amo_src",    64'(l15_req_src_o),    64'd1);
    check("amo_state_wait", 64'(dut.state_q), 64'd2);
    dc_req_type_i  = DCACHE_STORE_REQ;
    dc_req_paddr_i = 56'h00_4000_0200;
    dc_req_size_i  = 3'b010;
    dc_req_data_i  = 64'h1122_3344_5566_7788;
    settle();
    check("amo_st_held", 64'(dc_req_ready_o), 64'd0);
    step();
    dc_rtrn_i = 1'b1;
    settle();
    check("amo_st_held_rtrn", 64'(dc_req_ready_o), 64'd0);
    step();
    dc_rtrn_i = 1'b0;
    check("amo_state_back", 64'(dut.state_q), 64'd0);
    settle();
    check("amo_st_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0;
    check("amo_st_rqtype", 64'(l15_req_rqtype_o), 64'(L15_STORE_RQ));
    check("amo_st_data",   l15_req_data_o,        64'h1122_3344_5566_7788);
    check("amo_st_size",   64'(l15_req_size_o),   64'd2);
    dc_rtrn_i = 1'b1;
    ic_rtrn_i = 1'b1;
    step();
    dc_rtrn_i = 1'b0;
    ic_rtrn_i = 1'b0;
    check("amo_ic_cnt_clr", 64'(dut.ic_cnt_q), 64'd0);
    check("amo_dc_cnt_clr", 64'(dut.dc_cnt_q), 64'd0);

    // ---------------- backpressure ----------------
    l15_req_ready_i = 1'b0;
    ic_req_valid_i  = 1'b1;
    ic_req_paddr_i  = 56'h00_6000_0040;
    ic_req_tid_i    = 2'd3;
    settle();
    check("bp_first_ready", 64'(ic_req_ready_o), 64'd1);
    step();
    ic_req_paddr_i = 56'h00_6000_0080;
    dc_req_valid_i = 1'b1;
    dc_req_type_i  = DCACHE_LOAD_REQ;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("bp%0d_no_gnt", i), 64'({ic_req_ready_o, dc_req_ready_o}), 64'd0);
      step();
      check($sformatf("bp%0d_valid", i), 64'(l15_req_valid_o), 64'd1);
      check($sformatf("bp%0d_paddr", i), 64'(l15_req_paddr_o), 64'h00_6000_0040);
      check($sformatf("bp%0d_tid", i),   64'(l15_req_tid_o),   64'd3);
    end
    ic_req_valid_i  = 1'b0;
    dc_req_valid_i  = 1'b0;
    l15_req_ready_i = 1'b1;
    step();
    check("bp_single_xfer", 64'(l15_req_valid_o), 64'd0);
    check("bp_ic_cnt", 64'(dut.ic_cnt_q), 64'd1);
    ic_rtrn_i = 1'b1;
    step();
    ic_rtrn_i = 1'b0;

    // ---------------- reset mid-stall ----------------
    ic_req_valid_i = 1'b1;
    step();
    ic_req_valid_i = 1'b0;
    dc_req_valid_i = 1'b1;
    step();
    dc_req_valid_i = 1'b0;
    ic_req_valid_i = 1'b1;
    step();
    ic_req_valid_i  = 1'b0;
    dc_req_valid_i  = 1'b1;
    l15_req_ready_i = 1'b0;
    settle();
    check("mr_stall_ready", 64'(dc_req_ready_o), 64'd0);
    check("mr_ic_cnt", 64'(dut.ic_cnt_q), 64'd2);
    check("mr_dc_cnt", 64'(dut.dc_cnt_q), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("mr");
    check("mr_dc_ready", 64'(dc_req_ready_o), 64'd0);
    step();
    rst_ni = 1'b1;
    dc_req_type_i  = DCACHE_INT_REQ;
    dc_req_paddr_i = 56'h00_7000_0000;
    dc_req_size_i  = 3'b010;
    dc_req_data_i  = 64'h0000_0000_CAFE_F00D;
    settle();
    check("mr_ic_cnt_clr", 64'(dut.ic_cnt_q), 64'd0);
    check("mr_dc_cnt_clr", 64'(dut.dc_cnt_q), 64'd0);
    check("mr_first_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0;
    check("mr_valid",  64'(l15_req_valid_o),  64'd1);
    check("mr_rqtype", 64'(l15_req_rqtype_o), 64'(L15_INT_RQ));
    check("mr_size",   64'(l15_req_size_o),   64'd2);
    check("mr_data",   l15_req_data_o,        64'h0000_0000_CAFE_F00D);
    check("mr_src",    64'(l15_req_src_o),    64'd1);
    l15_req_ready_i = 1'b1;
    step();
    check("mr_drain", 64'(l15_req_valid_o), 64'd0);
    dc_rtrn_i = 1'b1;
    step();
    dc_rtrn_i = 1'b0;

    // ---------------- spurious return ----------------
    ic_rtrn_i = 1'b1;
    step();
    ic_rtrn_i = 1'b0;
    check("sp_ic_cnt",  64'(dut.ic_cnt_q),    64'd0);
    check("sp_valid",   64'(l15_req_valid_o), 64'd0);
    check("sp_paddr",   64'(l15_req_paddr_o), 64'h00_7000_0000);
    step();
    check("sp_ic_cnt2", 64'(dut.ic_cnt_q),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
